// File: rtl/mux_rr_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_sched_if
//  Description : Request/data/grant bundle between requesters, the
//                round-robin scheduler and the shared serial output.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_rr_sched_if #(
    parameter int N  = 8,
    parameter int SW = 3
);
    logic [N-1:0]  req;    // bit i: requester i wants the output
    logic [N-1:0]  din;    // mux data inputs, din[i] owned by requester i
    logic [SW-1:0] s;      // mux select (current/last grantee)
    logic [N-1:0]  gnt;    // one-hot grant, zero when idle
    logic          y;      // registered mux output
    logic          y_vld;  // y is a valid sample of an active grantee

    // Requester / datapath side
    modport master (
        output req,
        output din,
        input  s,
        input  gnt,
        input  y,
        input  y_vld
    );

    // Scheduler side
    modport slave (
        input  req,
        input  din,
        output s,
        output gnt,
        output y,
        output y_vld
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_sched
//  Description : Round-robin scheduler for a shared N:1 mux. Picks a winner
//                after the last grantee, holds it for at most HOLD cycles,
//                drives the registered select/grant and registers din[s].
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_sched #(
    parameter int N    = 8,
    parameter int SW   = 3,
    parameter int HOLD = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mux_rr_sched_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0]   c_hold_last = 8'(HOLD - 1);
    localparam logic [N-1:0] c_one       = {{(N-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0] c_ptr_rst  = SW'(N - 1);

    state_t        r_state;
    logic [SW-1:0] r_s;
    logic [SW-1:0] r_ptr;
    logic [N-1:0]  r_gnt;
    logic [7:0]    r_cnt;
    logic          r_y;
    logic          r_y_vld;

    logic [SW-1:0] w_pick;
    logic          w_any;
    logic          w_slot_end;

    // Round-robin pick: first set request after r_ptr, r_ptr itself scanned last
    always_comb begin
        w_pick = r_ptr;
        for (int k = N - 1; k >= 1; k--) begin
            if (bus.req[SW'((int'(r_ptr) + k) % N)]) begin
                w_pick = SW'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_any      = |bus.req;
    assign w_slot_end = (r_cnt == c_hold_last) || !bus.req[r_s];

    // Grant FSM plus registered select, grant and data sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_ptr   <= c_ptr_rst;
            r_y     <= 1'b0;
            r_y_vld <= 1'b0;
        end else begin
            // Data path samples the select that was on the mux this cycle
            r_y     <= bus.din[r_s];
            r_y_vld <= (r_state == ST_GRANT) && bus.req[r_s];

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= c_one << w_pick;
                        r_s     <= w_pick;
                        r_ptr   <= w_pick;
                        r_cnt   <= '0;
                    end else begin
                        r_gnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!w_slot_end) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else if (w_any) begin
                        // Back-to-back re-arbitration, no idle gap
                        r_gnt <= c_one << w_pick;
                        r_s   <= w_pick;
                        r_ptr <= w_pick;
                        r_cnt <= '0;
                    end else begin
                        // Select keeps the last grantee while idle
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.s     = r_s;
    assign bus.gnt   = r_gnt;
    assign bus.y     = r_y;
    assign bus.y_vld = r_y_vld;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_rr_sched
//  Description : Bench for mux_rr_sched. Two instances (HOLD=4, HOLD=1) share
//                stimulus; directed scenarios plus a randomized run against a
//                slot-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_sched;
    localparam int N  = 8;
    localparam int SW = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_v = '0;
    logic [N-1:0] din_v = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_rr_sched_if #(.N(N), .SW(SW)) bus0 ();
    mux_rr_sched_if #(.N(N), .SW(SW)) bus1 ();

    assign bus0.req = req_v;
    assign bus0.din = din_v;
    assign bus1.req = req_v;
    assign bus1.din = din_v;

    mux_rr_sched #(.N(N), .SW(SW), .HOLD(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mux_rr_sched #(.N(N), .SW(SW), .HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // ---------------- reference model (per instance) ----------------
    int   m_hold [2] = '{4, 1};
    bit   m_act  [2];
    int   m_own  [2];
    int   m_used [2];
    int   m_last [2];
    int   m_s    [2];
    logic m_y    [2];
    logic m_vld  [2];

    function automatic int pick(int last, logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_gnt(int i);
        logic [N-1:0] g;
        g = '0;
        if (m_act[i]) g[m_own[i]] = 1'b1;
        return g;
    endfunction

    task automatic model_step(int i);
        logic nv, nvld;
        int w;
        if (rst) begin
            m_act[i] = 0; m_own[i] = 0; m_used[i] = 0; m_last[i] = N - 1;
            m_s[i] = 0; m_y[i] = 1'b0; m_vld[i] = 1'b0;
            return;
        end
        nv   = din_v[m_s[i]];
        nvld = m_act[i] && req_v[m_s[i]];
        w    = pick(m_last[i], req_v);
        if (m_act[i]) begin
            m_used[i]++;
            if (m_used[i] >= m_hold[i] || !req_v[m_own[i]]) begin
                if (w >= 0) begin
                    m_own[i] = w; m_s[i] = w; m_last[i] = w; m_used[i] = 0;
                end else begin
                    m_act[i] = 0;
                end
            end
        end else if (w >= 0) begin
            m_act[i] = 1; m_own[i] = w; m_s[i] = w; m_last[i] = w; m_used[i] = 0;
        end
        m_y[i]   = nv;
        m_vld[i] = nvld;
    endtask

    // One clock: model follows the edge, outputs settle before inspection
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_v = '0; din_v = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; req_v = 8'hFF; din_v = 8'hFF;
        tick(); tick();
        checks++; if (bus0.s !== 3'd0) begin errors++; $display("FAIL reset_s got %0d exp 0", bus0.s); end
        checks++; if (bus0.gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got %h exp 00", bus0.gnt); end
        checks++; if (bus0.y !== 1'b0) begin errors++; $display("FAIL reset_y got %b exp 0", bus0.y); end
        checks++; if (bus0.y_vld !== 1'b0) begin errors++; $display("FAIL reset_yvld got %b exp 0", bus0.y_vld); end
        checks++; if (bus1.gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt_h1 got %h exp 00", bus1.gnt); end
        rst = 1'b0;
        tick();
        checks++; if (bus0.gnt !== 8'h01) begin errors++; $display("FAIL release_gnt got %h exp 01", bus0.gnt); end
        checks++; if (bus1.gnt !== 8'h01) begin errors++; $display("FAIL release_gnt_h1 got %h exp 01", bus1.gnt); end
    endtask

    task automatic test_single();
        do_reset();
        req_v = 8'h01; din_v = 8'h01;
        tick();
        checks++; if (bus0.gnt !== 8'h01) begin errors++; $display("FAIL single_first got %h exp 01", bus0.gnt); end
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (bus0.gnt !== 8'h01 || bus0.y !== 1'b1 || bus0.y_vld !== 1'b1) begin
                errors++;
                $display("FAIL single_hold cyc %0d got gnt=%h y=%b vld=%b exp gnt=01 y=1 vld=1",
                         k, bus0.gnt, bus0.y, bus0.y_vld);
            end
        end
    endtask

    task automatic test_rotate();
        logic [N-1:0] eg;
        do_reset();
        req_v = 8'hFF;
        tick();
        for (int k = 0; k < 36; k++) begin
            eg = 8'h01 << ((k / 4) % 8);
            checks++;
            if (bus0.gnt !== eg || bus0.s !== 3'((k / 4) % 8)) begin
                errors++;
                $display("FAIL rotate cyc %0d got gnt=%h s=%0d exp gnt=%h s=%0d",
                         k, bus0.gnt, bus0.s, eg, (k / 4) % 8);
            end
            if (k > 0) begin
                checks++;
                if (bus0.y_vld !== 1'b1) begin errors++; $display("FAIL rotate_vld cyc %0d got %b exp 1", k, bus0.y_vld); end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] e0, e1;
        do_reset();
        req_v = 8'h80;
        tick();
        req_v = 8'h84;
        for (int k = 0; k < 12; k++) begin
            e0 = ((k / 4) % 2 == 0) ? 8'h80 : 8'h04;
            e1 = (k % 2 == 0) ? 8'h80 : 8'h04;
            checks++;
            if (bus0.gnt !== e0) begin errors++; $display("FAIL wrap_h4 cyc %0d got %h exp %h", k, bus0.gnt, e0); end
            checks++;
            if (bus1.gnt !== e1) begin errors++; $display("FAIL wrap_h1 cyc %0d got %h exp %h", k, bus1.gnt, e1); end
            tick();
        end
    endtask

    task automatic test_drop();
        int n;
        do_reset();
        req_v = 8'hFF;
        tick();
        n = 0;
        while (bus0.gnt !== 8'h08 && n < 64) begin tick(); n++; end
        checks++;
        if (bus0.gnt !== 8'h08) begin errors++; $display("FAIL drop_wait got %h exp 08 (timeout)", bus0.gnt); end
        tick();
        req_v = 8'hF7;
        checks++; if (bus0.gnt !== 8'h08) begin errors++; $display("FAIL drop_overlap got %h exp 08", bus0.gnt); end
        tick();
        checks++; if (bus0.gnt !== 8'h10) begin errors++; $display("FAIL drop_next got %h exp 10", bus0.gnt); end
        checks++; if (bus0.y_vld !== 1'b0) begin errors++; $display("FAIL drop_vld got %b exp 0", bus0.y_vld); end
        tick();
        checks++; if (bus0.y_vld !== 1'b1) begin errors++; $display("FAIL drop_vld_next got %b exp 1", bus0.y_vld); end
    endtask

    task automatic test_rst_mid();
        int n;
        do_reset();
        req_v = 8'hFF; din_v = 8'hFF;
        tick();
        n = 0;
        while (bus0.s !== 3'd5 && n < 64) begin tick(); n++; end
        checks++;
        if (bus0.s !== 3'd5) begin errors++; $display("FAIL rstmid_wait got %0d exp 5 (timeout)", bus0.s); end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus0.s !== 3'd0 || bus0.gnt !== 8'h00 || bus0.y !== 1'b0 || bus0.y_vld !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_out got s=%0d gnt=%h y=%b vld=%b exp 0/00/0/0",
                     bus0.s, bus0.gnt, bus0.y, bus0.y_vld);
        end
        rst = 1'b0;
        tick();
        checks++; if (bus0.gnt !== 8'h01) begin errors++; $display("FAIL rstmid_first got %h exp 01", bus0.gnt); end
    endtask

    task automatic test_random();
        logic [N-1:0] g  [2];
        logic [SW-1:0] sv[2];
        logic yy [2];
        logic vv [2];
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            case ($urandom_range(0, 4))
                0: req_v = '0;
                1: req_v = N'($urandom);
                2: req_v = N'($urandom) & N'($urandom);
                3: req_v = 8'h01 << $urandom_range(0, N - 1);
                default: req_v = req_v;
            endcase
            din_v = N'($urandom);
            tick();
            g[0] = bus0.gnt; sv[0] = bus0.s; yy[0] = bus0.y; vv[0] = bus0.y_vld;
            g[1] = bus1.gnt; sv[1] = bus1.s; yy[1] = bus1.y; vv[1] = bus1.y_vld;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (g[i] !== m_gnt(i) || sv[i] !== 3'(m_s[i]) || yy[i] !== m_y[i] || vv[i] !== m_vld[i]) begin
                    errors++;
                    $display("FAIL random inst %0d cyc %0d got gnt=%h s=%0d y=%b vld=%b exp gnt=%h s=%0d y=%b vld=%b",
                             i, c, g[i], sv[i], yy[i], vv[i], m_gnt(i), m_s[i], m_y[i], m_vld[i]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_wrap();
        test_drop();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
